// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   FWD_RF / FWD_WB / FWD_MEM  forwarding-select encodings for the EX operand muxes
//   REG_ZERO                   architectural zero register; never a hazard source
//   md_state_e                 mult/div busy-timer state encoding
//   reg_hit()                  register-number match that ignores $0
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // A writer to $0 produces nothing observable, so it can never
    // satisfy a forward or stall compare.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Multi-cycle mult/div busy timer.
// Loads a down-counter on an accepted issue and reports busy until HI/LO
// would be valid. An issue at cycle t gives busy in cycles t+1..t+N.
// Ports:
//   Clk     in   pipeline clock, rising edge
//   Reset   in   synchronous, active-high reset
//   start   in   accepted mult/div issue this cycle
//   is_div  in   with start: 1 = div latency, 0 = mult latency
//   busy    out  timer active
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // statement so no path leaves a value unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // The counter only ever loads here, so garbage on is_div
                // cannot reach state without an accepted issue.
                if (start) begin
                    cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The "<=" also drains a counter that somehow reads 0.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Generates the stall and flush controls plus the operand forwarding
// selects. It also holds mult/div/mfhi/mflo in ID while the mult/div unit
// is still producing HI/LO.
// Ports:
//   Clk, Reset                          clock, synchronous active-high reset
//   RsD, RtD, BranchD                   ID-stage sources and branch flag
//   MdStartD, MdDivD, MdUseD            ID-stage mult/div issue and HI/LO use
//   RsE, RtE, WriteRegE, RegWriteE,
//   MemtoRegE                           EX-stage sources and destination
//   WriteRegM, RegWriteM, MemtoRegM     MEM-stage destination
//   WriteRegW, RegWriteW                WB-stage destination
//   StallF, StallD, FlushE              hold PC, hold IF/ID, bubble ID/EX
//   ForwardAD, ForwardBD                branch comparator operand from MEM
//   ForwardAE, ForwardBE                EX operand select (RF / WB / MEM)
//   MdBusy                              mult/div timer active
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       BranchD,
    input  logic       MdStartD,
    input  logic       MdDivD,
    input  logic       MdUseD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic [4:0] WriteRegM,
    input  logic       RegWriteM,
    input  logic       MemtoRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MdBusy
);

    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic stall;
    logic md_busy;

    // A load in EX has no data until the end of MEM, so any consumer in ID
    // must wait one cycle.
    assign lw_stall = MemtoRegE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD));

    // The branch compares in ID, so a result still in EX, or load data still
    // in MEM, cannot be forwarded to it in time.
    assign br_stall = BranchD &&
                      ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
                       (MemtoRegM && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));

    assign md_stall = (MdStartD || MdUseD) && md_busy;
    assign stall    = lw_stall || br_stall || md_stall;

    // An issue that is held for any reason does not start the timer.
    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_timer (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (MdStartD && !stall),
        .is_div (MdDivD),
        .busy   (md_busy)
    );

    assign MdBusy = md_busy;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (Reset) begin
            // Keep a bubble in EX and forwarding off while the pipe resets.
            FlushE = 1'b1;
        end else begin
            StallF = stall;
            StallD = stall;
            FlushE = stall;

            ForwardAD = RegWriteM && reg_hit(WriteRegM, RsD);
            ForwardBD = RegWriteM && reg_hit(WriteRegM, RtD);

            // MEM is checked first: it holds the younger value.
            if (RegWriteM && reg_hit(WriteRegM, RsE)) begin
                ForwardAE = FWD_MEM;
            end else if (RegWriteW && reg_hit(WriteRegW, RsE)) begin
                ForwardAE = FWD_WB;
            end

            if (RegWriteM && reg_hit(WriteRegM, RtE)) begin
                ForwardBE = FWD_MEM;
            end else if (RegWriteW && reg_hit(WriteRegW, RtE)) begin
                ForwardBE = FWD_WB;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. A reference model computes the expected
// outputs from the hazard rules every cycle. The mult/div timer is modelled
// as a count of remaining busy cycles. Literal checks in the stimulus pin the
// model to hand-computed values.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, MdStartD, MdDivD, MdUseD;
    logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0] ForwardAE, ForwardBE;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int md_left = 0;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
        .MdStartD(MdStartD), .MdDivD(MdDivD), .MdUseD(MdUseD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic bit m_stall();
        bit lw, br, md;
        lw = MemtoRegE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD));
        br = BranchD && ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                         (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
        md = (MdStartD || MdUseD) && (md_left > 0);
        return lw || br || md;
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
        if (RegWriteM && hit(WriteRegM, src)) return 2'd2;
        if (RegWriteW && hit(WriteRegW, src)) return 2'd1;
        return 2'd0;
    endfunction

    // Busy-cycle bookkeeping: an accepted issue leaves N busy cycles ahead.
    always @(posedge Clk) begin
        if (Reset) md_left = 0;
        else if (md_left > 0) md_left = md_left - 1;
        else if (MdStartD && !m_stall()) md_left = MdDivD ? DIV_N : MULT_N;
    end

    // Compare every output against the model on every falling edge.
    always @(negedge Clk) begin
        if (check_en) begin
            bit s;
            s = Reset ? 1'b0 : m_stall();
            check("cyc_StallF", 8'(StallF), 8'(s));
            check("cyc_StallD", 8'(StallD), 8'(s));
            check("cyc_FlushE", 8'(FlushE), 8'(Reset ? 1'b1 : s));
            check("cyc_ForwardAD", 8'(ForwardAD), 8'(!Reset && RegWriteM && hit(WriteRegM, RsD)));
            check("cyc_ForwardBD", 8'(ForwardBD), 8'(!Reset && RegWriteM && hit(WriteRegM, RtD)));
            check("cyc_ForwardAE", 8'(ForwardAE), 8'(Reset ? 2'd0 : m_fwd_e(RsE)));
            check("cyc_ForwardBE", 8'(ForwardBE), 8'(Reset ? 2'd0 : m_fwd_e(RtE)));
            check("cyc_MdBusy", 8'(MdBusy), 8'(md_left > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear();
        RsD = 0; RtD = 0; BranchD = 0; MdStartD = 0; MdDivD = 0; MdUseD = 0;
        RsE = 0; RtE = 0; WriteRegE = 0; RegWriteE = 0; MemtoRegE = 0;
        WriteRegM = 0; RegWriteM = 0; MemtoRegM = 0; WriteRegW = 0; RegWriteW = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        clear();
        tick();
        check_en = 1'b1;

        // Hazards presented during reset are overridden.
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5;
        RegWriteM = 1; WriteRegM = 8; RsE = 8;
        #1;
        check("rst_StallF", 8'(StallF), 8'd0);
        check("rst_FlushE", 8'(FlushE), 8'd1);
        check("rst_ForwardAE", 8'(ForwardAE), 8'd0);
        check("rst_MdBusy", 8'(MdBusy), 8'd0);

        // Forwarding: MEM beats WB on rs.
        tick(); Reset = 0; clear();
        RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8; RtE = 9;
        #1;
        check("fwd_mem_wins", 8'(ForwardAE), 8'd2);
        check("fwd_rt_none", 8'(ForwardBE), 8'd0);

        // WB-only on rt.
        tick(); clear();
        RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 9; RsE = 8; RtE = 9;
        #1;
        check("fwd_wb_rt", 8'(ForwardBE), 8'd1);
        check("fwd_mem_rs", 8'(ForwardAE), 8'd2);

        // $0 never forwards.
        tick(); clear();
        RegWriteM = 1; WriteRegM = 0; RegWriteW = 1; WriteRegW = 0; RsE = 0; RtE = 0; RsD = 0;
        #1;
        check("fwd_r0_AE", 8'(ForwardAE), 8'd0);
        check("fwd_r0_AD", 8'(ForwardAD), 8'd0);

        // Load-use: one stall cycle, then the load sits in MEM.
        tick(); clear();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5;
        #1;
        check("lw_stall", 8'(StallF), 8'd1);
        check("lw_flush", 8'(FlushE), 8'd1);
        tick(); clear();
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5; RtD = 5;
        #1;
        check("lw_released", 8'(StallD), 8'd0);
        tick(); clear();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 0; RtD = 0;
        #1;
        check("lw_r0_nostall", 8'(StallF), 8'd0);

        // Branch on an EX result stalls, then forwards from MEM.
        tick(); clear();
        BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
        #1;
        check("br_stall", 8'(StallF), 8'd1);
        tick(); clear();
        BranchD = 1; RsD = 3; RegWriteM = 1; WriteRegM = 3;
        #1;
        check("br_nostall", 8'(StallF), 8'd0);
        check("br_fwdAD", 8'(ForwardAD), 8'd1);

        // Divide accepted at t, HI/LO use held from t+1.
        tick(); clear();
        MdStartD = 1; MdDivD = 1;
        #1;
        check("div_issue_nostall", 8'(StallF), 8'd0);
        for (int i = 1; i <= DIV_N; i++) begin
            tick(); clear(); MdUseD = 1;
            #1;
            check("div_busy", 8'(MdBusy), 8'd1);
            check("div_use_stall", 8'(StallD), 8'd1);
        end
        tick(); clear(); MdUseD = 1;
        #1;
        check("div_done_busy", 8'(MdBusy), 8'd0);
        check("div_done_stall", 8'(StallF), 8'd0);

        // Multiply at t; a second issue from t+2 waits without reloading.
        tick(); clear();
        MdStartD = 1;
        tick(); clear();
        #1;
        check("mul_busy_t1", 8'(MdBusy), 8'd1);
        for (int i = 2; i <= MULT_N; i++) begin
            tick(); clear(); MdStartD = 1;
            #1;
            check("mul_second_held", 8'(StallF), 8'd1);
        end
        tick(); clear(); MdStartD = 1;
        #1;
        check("mul_t6_idle", 8'(MdBusy), 8'd0);
        check("mul_t6_accept", 8'(StallF), 8'd0);
        tick(); clear();
        #1;
        check("mul_second_busy", 8'(MdBusy), 8'd1);
        for (int i = 0; i < MULT_N; i++) tick();
        #1;
        check("mul_second_done", 8'(MdBusy), 8'd0);

        // Reset mid-divide.
        tick(); clear(); MdStartD = 1; MdDivD = 1;
        tick(); clear();
        tick();
        tick(); Reset = 1;
        tick();
        #1;
        check("rstmid_busy", 8'(MdBusy), 8'd0);
        check("rstmid_flush", 8'(FlushE), 8'd1);
        tick(); Reset = 0; MdUseD = 1;
        #1;
        check("rstmid_nostall", 8'(StallF), 8'd0);

        // A divide held by a load-use hazard is not accepted.
        tick(); clear();
        MdStartD = 1; MdDivD = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
        #1;
        check("md_lw_stall", 8'(StallF), 8'd1);
        tick(); clear();
        #1;
        check("md_lw_noload", 8'(MdBusy), 8'd0);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
